// File: rtl/cv32e40px_x_coproc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cv32e40px_x_coproc_pkg
// Purpose : Shared types for the custom-0 coprocessor responder: operation
//           enum, decode field constants and the queue entry layout.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package cv32e40px_x_coproc_pkg;

  typedef enum logic [1:0] {
    OP_ADD3 = 2'd0,
    OP_SUBR = 2'd1,
    OP_MINU = 2'd2
  } op_e;

  localparam logic [2:0] C_FUNCT3_ADD3 = 3'b000;
  localparam logic [2:0] C_FUNCT3_SUBR = 3'b001;
  localparam logic [2:0] C_FUNCT3_MINU = 3'b010;
  localparam logic [6:0] C_FUNCT7_ZERO = 7'b000_0000;
  // ADD3 is R4-style: instr[31:27] names rs3, instr[26:25] must be zero.
  localparam logic [1:0] C_ADD3_FMT    = 2'b00;

  typedef struct packed {
    logic [3:0]  id;
    logic [4:0]  rd;
    op_e         op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rs3;
    logic        committed;
    logic        killed;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/cv32e40px_x_coproc_alu.sv
`default_nettype none
// ============================================================================
// Module  : cv32e40px_x_coproc_alu
// Purpose : Combinational execute stage of the coprocessor.
// Ports   : op_i      operation (op_e encoding)
//           rs1_i..rs3_i  source operands
//           result_o  32-bit result, wraps modulo 2^32
// Rev     : 1.0  initial release
// ============================================================================
module cv32e40px_x_coproc_alu
  import cv32e40px_x_coproc_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rs3_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = '0;
    case (op_e'(op_i))
      OP_ADD3: result_o = rs1_i + rs2_i + rs3_i;
      OP_SUBR: result_o = rs1_i - rs2_i;
      OP_MINU: result_o = (rs1_i < rs2_i) ? rs1_i : rs2_i;
      default: result_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cv32e40px_x_coproc_responder.sv
`default_nettype none
// ============================================================================
// Module  : cv32e40px_x_coproc_responder
// Purpose : Coprocessor side of the CORE-V-XIF issue/commit/result channels.
//           Decodes custom-0 instructions, queues accepted ones in order until
//           committed or killed, executes committed ones and returns results
//           through a registered, back-pressured result channel.
// Ports   : clk_i / rst_i            clock, synchronous active-high reset
//           issue_*                  issue request/response
//           commit_*                 commit or kill by instruction ID
//           result_*                 result channel (valid/ready)
// Rev     : 1.0  initial release
// ============================================================================
module cv32e40px_x_coproc_responder
  import cv32e40px_x_coproc_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter logic [6:0]  OPCODE = 7'h0B
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        issue_valid_i,
  output logic        issue_ready_o,
  input  logic [31:0] issue_req_instr_i,
  input  logic [3:0]  issue_req_id_i,
  input  logic [95:0] issue_req_rs_i,
  input  logic [2:0]  issue_req_rs_valid_i,
  output logic        issue_resp_accept_o,
  output logic        issue_resp_writeback_o,
  output logic        issue_resp_dualread_o,
  output logic        issue_resp_loadstore_o,
  input  logic        commit_valid_i,
  input  logic [3:0]  commit_id_i,
  input  logic        commit_kill_i,
  output logic        result_valid_o,
  input  logic        result_ready_i,
  output logic [3:0]  result_id_o,
  output logic [4:0]  result_rd_o,
  output logic [31:0] result_data_o,
  output logic        result_we_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // ---------------------------------------------------------------- decode
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_hit;
  logic       w_need_rs3;
  op_e        w_op;
  logic       w_rs_ok;
  logic       w_unused_instr;

  assign w_opcode = issue_req_instr_i[6:0];
  assign w_funct3 = issue_req_instr_i[14:12];
  assign w_funct7 = issue_req_instr_i[31:25];
  // Register-address fields are not needed: operands arrive as values.
  assign w_unused_instr = ^issue_req_instr_i[24:15];

  always_comb begin
    w_hit      = 1'b0;
    w_need_rs3 = 1'b0;
    w_op       = OP_ADD3;
    if (w_opcode == OPCODE) begin
      case (w_funct3)
        C_FUNCT3_ADD3: begin
          if (issue_req_instr_i[26:25] == C_ADD3_FMT) begin
            w_hit      = 1'b1;
            w_need_rs3 = 1'b1;
            w_op       = OP_ADD3;
          end
        end
        C_FUNCT3_SUBR: begin
          if (w_funct7 == C_FUNCT7_ZERO) begin
            w_hit = 1'b1;
            w_op  = OP_SUBR;
          end
        end
        C_FUNCT3_MINU: begin
          if (w_funct7 == C_FUNCT7_ZERO) begin
            w_hit = 1'b1;
            w_op  = OP_MINU;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_rs_ok = issue_req_rs_valid_i[0] & issue_req_rs_valid_i[1] &
                   (~w_need_rs3 | issue_req_rs_valid_i[2]);

  // ----------------------------------------------------------------- queue
  entry_t             r_q   [DEPTH];
  logic               r_vld [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  logic               r_res_valid;
  logic [3:0]         r_res_id;
  logic [4:0]         r_res_rd;
  logic [31:0]        r_res_data;

  entry_t             w_new;
  entry_t             w_head;
  logic               w_head_vld;
  logic               w_not_full;
  logic               w_push;
  logic               w_drop;
  logic               w_retire;
  logic               w_pop;
  logic [31:0]        w_alu_res;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Readiness ignores a same-cycle pop: a full queue never takes a push.
  assign w_not_full    = (r_count < CNT_W'(DEPTH));
  assign issue_ready_o = w_not_full & (~w_hit | w_rs_ok);
  assign w_push        = issue_valid_i & issue_ready_o & w_hit;

  assign issue_resp_accept_o    = w_hit;
  assign issue_resp_writeback_o = w_hit;
  assign issue_resp_dualread_o  = 1'b0;
  assign issue_resp_loadstore_o = 1'b0;

  // New entry picks up a commit/kill aimed at it in its own issue cycle.
  always_comb begin
    w_new           = '0;
    w_new.id        = issue_req_id_i;
    w_new.rd        = issue_req_instr_i[11:7];
    w_new.op        = w_op;
    w_new.rs1       = issue_req_rs_i[31:0];
    w_new.rs2       = issue_req_rs_i[63:32];
    w_new.rs3       = issue_req_rs_i[95:64];
    w_new.committed = commit_valid_i & ~commit_kill_i & (commit_id_i == issue_req_id_i);
    w_new.killed    = commit_valid_i &  commit_kill_i & (commit_id_i == issue_req_id_i);
  end

  assign w_head     = r_q[r_head];
  assign w_head_vld = r_vld[r_head];
  assign w_drop     = w_head_vld & w_head.killed;
  assign w_retire   = w_head_vld & w_head.committed & ~w_head.killed &
                      (~r_res_valid | result_ready_i);
  assign w_pop      = w_drop | w_retire;

  // Per-entry storage; flags change only once (first commit/kill wins).
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic w_commit_hit;
    assign w_commit_hit = commit_valid_i & r_vld[gi] & (r_q[gi].id == commit_id_i) &
                          ~r_q[gi].committed & ~r_q[gi].killed;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_vld[gi] <= 1'b0;
      end else if (w_push && (r_tail == PTR_W'(gi))) begin
        r_q[gi]   <= w_new;
        r_vld[gi] <= 1'b1;
      end else begin
        if (w_pop && (r_head == PTR_W'(gi))) begin
          r_vld[gi] <= 1'b0;
        end
        if (w_commit_hit) begin
          if (commit_kill_i) begin
            r_q[gi].killed <= 1'b1;
          end else begin
            r_q[gi].committed <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_head <= ptr_inc(r_head);
      end
      if (w_push) begin
        r_tail <= ptr_inc(r_tail);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // --------------------------------------------------------------- execute
  cv32e40px_x_coproc_alu u_alu (
    .op_i     (w_head.op),
    .rs1_i    (w_head.rs1),
    .rs2_i    (w_head.rs2),
    .rs3_i    (w_head.rs3),
    .result_o (w_alu_res)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_rd    <= '0;
      r_res_data  <= '0;
    end else if (w_retire) begin
      r_res_valid <= 1'b1;
      r_res_id    <= w_head.id;
      r_res_rd    <= w_head.rd;
      r_res_data  <= w_alu_res;
    end else if (result_ready_i) begin
      r_res_valid <= 1'b0;
    end
  end

  assign result_valid_o = r_res_valid;
  assign result_id_o    = r_res_id;
  assign result_rd_o    = r_res_rd;
  assign result_data_o  = r_res_data;
  assign result_we_o    = r_res_valid;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40px_x_coproc_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_cv32e40px_x_coproc_responder
// Purpose : Self-checking bench for the custom-0 coprocessor responder:
//           directed scenarios plus a randomized run against a queue-based
//           reference model of in-order commit/kill/result behaviour.
// Rev     : 1.0  initial release
// ============================================================================
module tb_cv32e40px_x_coproc_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] instr;
  logic [3:0]  iid;
  logic [95:0] rs;
  logic [2:0]  rs_valid;
  logic        accept, writeback, dualread, loadstore;
  logic        commit_valid;
  logic [3:0]  commit_id;
  logic        commit_kill;
  logic        result_valid;
  logic        result_ready;
  logic [3:0]  result_id;
  logic [4:0]  result_rd;
  logic [31:0] result_data;
  logic        result_we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cv32e40px_x_coproc_responder #(.DEPTH(4), .OPCODE(7'h0B)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .issue_valid_i          (issue_valid),
    .issue_ready_o          (issue_ready),
    .issue_req_instr_i      (instr),
    .issue_req_id_i         (iid),
    .issue_req_rs_i         (rs),
    .issue_req_rs_valid_i   (rs_valid),
    .issue_resp_accept_o    (accept),
    .issue_resp_writeback_o (writeback),
    .issue_resp_dualread_o  (dualread),
    .issue_resp_loadstore_o (loadstore),
    .commit_valid_i         (commit_valid),
    .commit_id_i            (commit_id),
    .commit_kill_i          (commit_kill),
    .result_valid_o         (result_valid),
    .result_ready_i         (result_ready),
    .result_id_o            (result_id),
    .result_rd_o            (result_rd),
    .result_data_o          (result_data),
    .result_we_o            (result_we)
  );

  // ------------------------------------------------------ reference model
  typedef struct {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          committed;
  } item_t;

  item_t outs[$];

  function automatic bit ref_hit(input logic [31:0] w);
    if (w[6:0] != 7'h0B) return 1'b0;
    if (w[14:12] == 3'd0) return (w[26:25] == 2'd0);
    if (w[14:12] == 3'd1 || w[14:12] == 3'd2) return (w[31:25] == 7'd0);
    return 1'b0;
  endfunction

  function automatic bit ref_rs_ok(input logic [31:0] w, input logic [2:0] v);
    if (!(v[0] && v[1])) return 1'b0;
    if (w[14:12] == 3'd0) return v[2];
    return 1'b1;
  endfunction

  function automatic logic [31:0] ref_data(input logic [31:0] w, input logic [95:0] r);
    logic [31:0] a, b, c;
    a = r[31:0]; b = r[63:32]; c = r[95:64];
    case (w[14:12])
      3'd0:    return a + b + c;
      3'd1:    return a - b;
      default: return (a < b) ? a : b;
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic idle_inputs();
    issue_valid  = 1'b0;
    instr        = '0;
    iid          = '0;
    rs           = '0;
    rs_valid     = '0;
    commit_valid = 1'b0;
    commit_id    = '0;
    commit_kill  = 1'b0;
    result_ready = 1'b1;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", result_valid); end
    checks++; if ({result_id, result_rd, result_data, result_we} !== '0) begin errors++;
      $display("FAIL reset_outputs got id=%0h rd=%0h data=%0h we=%0b want all 0", result_id, result_rd, result_data, result_we); end
    rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", issue_ready); end
  endtask

  task automatic test_latency();
    @(negedge clk);
    instr = mk({5'd7, 2'b00}, 3'd0, 5'd5, 7'h0B); iid = 4'd3;
    rs = {32'd3, 32'd2, 32'd1}; rs_valid = 3'b111; issue_valid = 1'b1;
    commit_valid = 1'b1; commit_id = 4'd3; commit_kill = 1'b0;
    #1;
    checks++; if ({issue_ready, accept, writeback} !== 3'b111) begin errors++;
      $display("FAIL add3_issue got ready/acc/wb=%b want 111", {issue_ready, accept, writeback}); end
    checks++; if ({dualread, loadstore} !== 2'b00) begin errors++;
      $display("FAIL tied_outputs got %b want 00", {dualread, loadstore}); end
    @(negedge clk); idle_inputs(); #1;
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL latency_n1 got valid=%0b want 0", result_valid); end
    @(negedge clk); #1;
    checks++; if ({result_valid, result_we, result_id, result_rd, result_data} !== {1'b1, 1'b1, 4'd3, 5'd5, 32'd6}) begin errors++;
      $display("FAIL latency_n2 got v=%0b we=%0b id=%0d rd=%0d data=%0d want v=1 we=1 id=3 rd=5 data=6",
               result_valid, result_we, result_id, result_rd, result_data); end
    @(negedge clk); #1;
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL latency_drain got valid=%0b want 0", result_valid); end
  endtask

  task automatic test_reject();
    bit seen;
    @(negedge clk);
    instr = {25'h0, 7'h33}; iid = 4'd2; rs_valid = 3'b111; issue_valid = 1'b1;
    #1;
    checks++; if ({issue_ready, accept, writeback} !== 3'b100) begin errors++;
      $display("FAIL reject_issue got ready/acc/wb=%b want 100", {issue_ready, accept, writeback}); end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); idle_inputs(); #1;
      if (result_valid) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL reject_no_result got result=1 want 0"); end
  endtask

  task automatic test_rs_stall();
    logic [95:0] r;
    r = {rnd32(), rnd32(), rnd32()};
    @(negedge clk);
    instr = mk({5'd9, 2'b00}, 3'd0, 5'd9, 7'h0B); iid = 4'd8; rs = r;
    rs_valid = 3'b011; issue_valid = 1'b1;
    #1;
    checks++; if ({issue_ready, accept} !== 2'b01) begin errors++;
      $display("FAIL rs_stall_c1 got ready/acc=%b want 01", {issue_ready, accept}); end
    @(negedge clk); #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL rs_stall_c2 got ready=%0b want 0", issue_ready); end
    @(negedge clk);
    rs_valid = 3'b111; commit_valid = 1'b1; commit_id = 4'd8; commit_kill = 1'b0;
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rs_stall_c3 got ready=%0b want 1", issue_ready); end
    @(negedge clk); idle_inputs();
    @(negedge clk); #1;
    checks++; if ({result_valid, result_id, result_data} !== {1'b1, 4'd8, r[31:0] + r[63:32] + r[95:64]}) begin errors++;
      $display("FAIL rs_stall_result got v=%0b id=%0d data=%0h want v=1 id=8 data=%0h",
               result_valid, result_id, result_data, r[31:0] + r[63:32] + r[95:64]); end
    @(negedge clk);
  endtask

  task automatic test_full();
    logic [31:0] exp_d [4];
    int          nres;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rs = {32'd0, rnd32(), rnd32()};
      exp_d[k] = rs[31:0] - rs[63:32];
      instr = mk(7'd0, 3'd1, 5'(k + 1), 7'h0B); iid = 4'(4 + k);
      rs_valid = 3'b111; issue_valid = 1'b1;
      #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL full_fill%0d got ready=%0b want 1", k, issue_ready); end
    end
    @(negedge clk); idle_inputs(); #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", issue_ready); end
    @(negedge clk);
    commit_valid = 1'b1; commit_id = 4'd4; commit_kill = 1'b0;
    #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL full_commit_cycle got ready=%0b want 0", issue_ready); end
    @(negedge clk); idle_inputs(); #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass got ready=%0b want 0", issue_ready); end
    @(negedge clk); #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL full_after_drain got ready=%0b want 1", issue_ready); end
    checks++; if ({result_valid, result_id, result_data} !== {1'b1, 4'd4, exp_d[0]}) begin errors++;
      $display("FAIL full_head_result got v=%0b id=%0d data=%0h want v=1 id=4 data=%0h", result_valid, result_id, result_data, exp_d[0]); end
    nres = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); idle_inputs();
      if (c < 3) begin commit_valid = 1'b1; commit_id = 4'(5 + c); end
      #1;
      if (result_valid) begin
        checks++;
        if (nres >= 4 || result_id !== 4'(4 + nres) || result_data !== exp_d[nres]) begin errors++;
          $display("FAIL full_order got id=%0d data=%0h at index %0d", result_id, result_data, nres); end
        nres++;
      end
    end
    checks++; if (nres != 4) begin errors++; $display("FAIL full_count got %0d results want 4", nres); end
  endtask

  task automatic test_kill();
    logic [31:0] exp_d [3];
    int          nres;
    logic [3:0]  want_id;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rs = {32'd0, rnd32(), rnd32()};
      exp_d[k] = (rs[31:0] < rs[63:32]) ? rs[31:0] : rs[63:32];
      instr = mk(7'd0, 3'd2, 5'(10 + k), 7'h0B); iid = 4'(k);
      rs_valid = 3'b111; issue_valid = 1'b1;
      #1;
    end
    nres = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk); idle_inputs();
      if (c == 0) begin commit_valid = 1'b1; commit_id = 4'd1; commit_kill = 1'b1; end
      if (c == 1) begin commit_valid = 1'b1; commit_id = 4'd0; end
      if (c == 2) begin commit_valid = 1'b1; commit_id = 4'd2; end
      #1;
      if (result_valid) begin
        want_id = (nres == 0) ? 4'd0 : 4'd2;
        checks++;
        if (nres >= 2 || result_id !== want_id || result_data !== exp_d[want_id]) begin errors++;
          $display("FAIL kill_order got id=%0d data=%0h at index %0d want id=%0d", result_id, result_data, nres, want_id); end
        nres++;
      end
    end
    checks++; if (nres != 2) begin errors++; $display("FAIL kill_count got %0d results want 2", nres); end
  endtask

  task automatic test_backpressure();
    logic [3:0]  hid;
    logic [31:0] hdata;
    bit          got, seen;
    @(negedge clk);
    rs = {rnd32(), rnd32(), rnd32()};
    instr = mk(7'd0, 3'd0, 5'd3, 7'h0B); iid = 4'd10; rs_valid = 3'b111; issue_valid = 1'b1;
    commit_valid = 1'b1; commit_id = 4'd10; result_ready = 1'b0;
    @(negedge clk);
    idle_inputs(); result_ready = 1'b0;
    instr = mk(7'd0, 3'd1, 5'd4, 7'h0B); iid = 4'd11; rs_valid = 3'b111; issue_valid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk); idle_inputs(); result_ready = 1'b0; #1;
      got = result_valid;
    end
    checks++; if (!got) begin errors++; $display("FAIL bp_timeout got valid=0 want 1"); end
    hid = result_id; hdata = result_data;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++; if ({result_valid, result_id, result_data} !== {1'b1, hid, hdata}) begin errors++;
        $display("FAIL bp_stable got v=%0b id=%0d data=%0h want v=1 id=%0d data=%0h", result_valid, result_id, result_data, hid, hdata); end
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL bp_reset got valid=%0b want 0", result_valid); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL bp_reset_queue got ready=%0b want 1", issue_ready); end
    @(negedge clk); idle_inputs(); commit_valid = 1'b1; commit_id = 4'd11;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); idle_inputs(); #1;
      if (result_valid) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL bp_discarded got result after reset want none"); end
  endtask

  task automatic test_random();
    logic [31:0] p_instr;
    logic [95:0] p_rs;
    logic [3:0]  p_id;
    bit          pend, hs, hit, stall_prev, draining;
    logic [3:0]  next_id;
    logic [3:0]  prev_id;
    logic [4:0]  prev_rd;
    logic [31:0] prev_data;
    int          r, pick, kind;
    int          idxq[$];
    item_t       it;
    pend = 0; next_id = 0; stall_prev = 0; outs.delete();
    for (int cyc = 0; cyc < 3300; cyc++) begin
      draining = (cyc >= 3000);
      @(negedge clk);
      idle_inputs();
      if (!pend && !draining && $urandom_range(0, 9) < 6) begin
        kind = $urandom_range(0, 7);
        p_rs = {rnd32(), rnd32(), rnd32()};
        if ($urandom_range(0, 7) == 0) p_rs[63:32] = p_rs[31:0];
        p_id = next_id;
        case (kind)
          0, 1: p_instr = mk({5'($urandom), 2'b00}, 3'd0, 5'($urandom), 7'h0B);
          2, 3: p_instr = mk(7'd0, 3'd1, 5'($urandom), 7'h0B);
          4, 5: p_instr = mk(7'd0, 3'd2, 5'($urandom), 7'h0B);
          6: begin p_instr = $urandom; if (p_instr[6:0] == 7'h0B) p_instr[6:0] = 7'h33; end
          default: p_instr = mk(7'($urandom_range(1, 127)), 3'($urandom_range(0, 7)), 5'($urandom), 7'h0B);
        endcase
        pend = 1;
      end
      issue_valid = pend; instr = p_instr; iid = p_id; rs = p_rs;
      rs_valid = (draining || $urandom_range(0, 3) != 0) ? 3'b111 : 3'($urandom);
      result_ready = draining ? 1'b1 : ($urandom_range(0, 9) < 7);
      #1;
      hs = 0; hit = 0;
      if (pend) begin
        hit = ref_hit(p_instr);
        checks++; if (accept !== hit || writeback !== hit) begin errors++;
          $display("FAIL rnd_decode instr=%08h got acc=%0b wb=%0b want %0b", p_instr, accept, writeback, hit); end
        checks++; if (issue_ready && hit && !ref_rs_ok(p_instr, rs_valid)) begin errors++;
          $display("FAIL rnd_rs_ready instr=%08h rs_valid=%b got ready=1 want 0", p_instr, rs_valid); end
        hs = issue_ready;
        if (hs) begin
          pend = 0;
          if (hit) begin
            it.id = p_id; it.rd = p_instr[11:7]; it.data = ref_data(p_instr, p_rs); it.committed = 0;
            outs.push_back(it);
            next_id = next_id + 4'd1;
          end
        end
      end
      r = $urandom_range(0, 99);
      idxq.delete();
      foreach (outs[i]) if (!outs[i].committed) idxq.push_back(i);
      if (hs && hit && r < 30) begin
        commit_valid = 1; commit_id = p_id; commit_kill = 0;
        outs[outs.size() - 1].committed = 1;
      end else if ((r < 55 || draining) && idxq.size() > 0) begin
        pick = idxq[$urandom_range(0, idxq.size() - 1)];
        commit_valid = 1; commit_id = outs[pick].id;
        commit_kill = !draining && ($urandom_range(0, 3) == 0);
        if (commit_kill) outs.delete(pick);
        else outs[pick].committed = 1;
      end else if (r >= 55 && r < 62) begin
        commit_valid = 1; commit_id = next_id + 4'd5; commit_kill = 1'($urandom);
      end else if (r >= 62 && r < 68 && outs.size() > 0 && outs[0].committed) begin
        commit_valid = 1; commit_id = outs[0].id; commit_kill = 1'($urandom);
      end
      if (stall_prev) begin
        checks++;
        if ({result_valid, result_id, result_rd, result_data} !== {1'b1, prev_id, prev_rd, prev_data}) begin errors++;
          $display("FAIL rnd_hold got v=%0b id=%0d data=%0h want v=1 id=%0d data=%0h", result_valid, result_id, result_data, prev_id, prev_data); end
      end
      if (result_valid && result_ready) begin
        checks++;
        if (outs.size() == 0) begin errors++;
          $display("FAIL rnd_result got unexpected id=%0d data=%0h want none", result_id, result_data);
        end else if (!outs[0].committed || result_we !== 1'b1 || result_id !== outs[0].id ||
                     result_rd !== outs[0].rd || result_data !== outs[0].data) begin errors++;
          $display("FAIL rnd_result got id=%0d rd=%0d data=%0h we=%0b want id=%0d rd=%0d data=%0h committed=%0b",
                   result_id, result_rd, result_data, result_we, outs[0].id, outs[0].rd, outs[0].data, outs[0].committed);
        end
        if (outs.size() > 0) void'(outs.pop_front());
      end
      stall_prev = result_valid && !result_ready;
      prev_id = result_id; prev_rd = result_rd; prev_data = result_data;
      if (draining && !pend && outs.size() == 0 && !result_valid) break;
    end
    checks++; if (outs.size() != 0 || pend) begin errors++;
      $display("FAIL rnd_drain got %0d outstanding pend=%0b want 0", outs.size(), pend); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_latency();
    test_reject();
    test_rs_stall();
    test_full();
    test_kill();
    test_backpressure();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
